switch_in_port: RTL and testbench
=================================

Name: switch_in_port

Overview:
- Ingress stage of the switch; sits directly behind the byte-serial input interface (data_in / sw_enable_in / read_out).
- Frames incoming bytes into packets, checks header and length, and buffers complete packets only.
- Forwards each packet to the switch core over a valid/ready byte stream with sop/eop markers.
- Malformed or unroutable packets are dropped and never reach the core.

Parameters:
- DEPTH, 128: packet buffer size in bytes; power of 2, minimum 64.
- MAX_LEN, 32: maximum payload bytes per packet.
- NUM_PORTS, 4: number of valid destination addresses.
- Valid destinations are DA = 0..NUM_PORTS-1.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  reset, asynchronous, active-high: asserted when 1. Name kept for interface compatibility.
- data_in  input  8  serial packet byte, sampled when sw_enable_in=1.
- sw_enable_in  input  1  high for exactly the bytes of one packet.
- read_out  output  1  busy; upstream must not start a packet while it is 1.
- out_data  output  8  byte to the switch core.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  core accepts the byte when out_valid and out_ready are both 1.
- out_sop  output  1  current byte is the DA (first) byte.
- out_eop  output  1  current byte is the last byte of the packet.
- out_dest  output  2  DA of the current packet; stable from sop through eop.

Behaviour:
- Packet format: DA, SA, LEN, then LEN payload bytes. LEN=0 is legal (3-byte packet).
- Reset: all outputs 0; FIFO empty; write, commit and read pointers = 0; FSM in IDLE. Any partial packet is discarded.
- Write FSM, transitions on sampled cycles:
  - IDLE: sw_enable_in=1 → write DA → SA. If read_out=1 at the start, → DROP instead.
  - SA: write SA → LEN.
  - LEN: write LEN.
    - If LEN>MAX_LEN or DA>=NUM_PORTS → DROP.
    - Else if LEN=0 → commit → IDLE.
    - Else → PAY.
  - PAY: write byte, decrement count. Last byte → commit → IDLE.
  - DROP: rewind write pointer to the commit pointer; ignore bytes until sw_enable_in=0 → IDLE.
- Abort: sw_enable_in=0 in SA, LEN or PAY → rewind write pointer → IDLE. The packet is lost.
- Overrun: sw_enable_in still 1 after commit → excess bytes ignored, no second packet started. The next packet needs sw_enable_in low for at least 1 cycle.
- Commit: the commit pointer advances at the same edge that writes the last byte. The reader sees only committed bytes.
- read_out: registered, = 1 when (DEPTH - committed occupancy) < MAX_LEN+3. Re-evaluated every cycle.
- Read side:
  - Tracks its own byte count; the third byte of each packet loads the remaining count.
  - out_sop=1 on the DA byte; out_eop=1 on the last byte (on LEN when LEN=0).
  - out_dest is loaded from DA and held until the eop byte is accepted.
- Output hold: out_data, out_sop, out_eop and out_valid hold steady while out_valid=1 and out_ready=0.
- Throughput: next byte presented the cycle after acceptance, giving 1 byte/clk when out_ready=1.
- Latency: out_valid with the DA byte rises exactly 2 clocks after the edge that samples the packet's last byte, when the buffer was empty.
- Pointers: log2(DEPTH)+1 bits; the wrap bit distinguishes full from empty. Byte storage wraps modulo DEPTH.
- Simultaneous commit and read in the same cycle are both honoured.

Optional Feature:
- Macro: SW_IN_PKT_CNT_EN.
- Defined: adds output pkt_ok_cnt [15:0], incremented once per committed packet, and output pkt_drop_cnt [15:0], incremented once per DROP entry or abort.
  - Both saturate at 16'hFFFF.
  - Both cleared by reset.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset, then packet DA=1, SA=7, LEN=2, payload AA,BB with out_ready=1 → out_valid rises 2 clks after BB sampled. Core sees 01,07,02,AA,BB on consecutive clks; sop on 01; eop on BB; out_dest=1.
- DA=2, LEN=0 → 3 bytes out, out_eop on the LEN byte.
- DA=5 (NUM_PORTS=4) and, separately, LEN=33 → nothing output. Next valid packet is delivered intact. pkt_drop_cnt=2 when SW_IN_PKT_CNT_EN is defined.
- sw_enable_in drops after 1 of 4 payload bytes → nothing output; buffer occupancy returns to its prior value.
- Hold out_ready=0 while sending 3 packets of LEN=32 → read_out=1 after the 3rd commit (occupancy 105, free 23 < 35). A 4th packet started anyway is dropped. Releasing out_ready drains 3 packets and clears read_out.
- Assert reset mid-PAY and mid-output → all outputs 0 immediately. After release a new packet passes normally with no stale bytes.

Source files
------------

// File: rtl/switch_in_port.sv
// switch_in_port: ingress stage of the switch.
//
// Frames byte-serial packets (DA, SA, LEN, LEN payload bytes) arriving on
// data_in while sw_enable_in is high, checks the header, and buffers only
// complete, routable packets. Buffered packets are forwarded to the switch
// core as a valid/ready byte stream with sop/eop markers and the packet's
// destination. Malformed, aborted or unroutable packets are discarded.
//
// Optional feature: define SW_IN_PKT_CNT_EN to add saturating packet
// counters pkt_ok_cnt / pkt_drop_cnt.
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous reset, active HIGH (name kept for compatibility)
//   data_in       serial packet byte, sampled while sw_enable_in=1
//   sw_enable_in  high for exactly the bytes of one packet
//   read_out      busy: upstream must not start a packet while high
//   out_data      byte to the switch core
//   out_valid     out_data is valid
//   out_ready     core accepts the byte when out_valid & out_ready
//   out_sop       current byte is the DA byte
//   out_eop       current byte is the last byte of the packet
//   out_dest      DA of the current packet, stable from sop through eop
//   pkt_ok_cnt    (SW_IN_PKT_CNT_EN) committed packet count, saturating
//   pkt_drop_cnt  (SW_IN_PKT_CNT_EN) dropped/aborted packet count, saturating
module switch_in_port #(
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned MAX_LEN   = 32,
    parameter int unsigned NUM_PORTS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data_in,
    input  logic        sw_enable_in,
    output logic        read_out,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sop,
    output logic        out_eop,
    output logic [1:0]  out_dest
`ifdef SW_IN_PKT_CNT_EN
    ,
    output logic [15:0] pkt_ok_cnt,
    output logic [15:0] pkt_drop_cnt
`endif
);

    localparam int unsigned AW          = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_P     = (AW+1)'(DEPTH);
    localparam logic [AW:0] ROOM        = (AW+1)'(MAX_LEN + 3);
    localparam logic [7:0]  MAX_LEN_B   = 8'(MAX_LEN);
    localparam logic [7:0]  NUM_PORTS_B = 8'(NUM_PORTS);

    // S_SKIP swallows overrun bytes after a commit until sw_enable_in drops,
    // so trailing bytes can never be mistaken for a new packet's DA.
    typedef enum logic [2:0] {S_IDLE, S_SA, S_LEN, S_PAY, S_DROP, S_SKIP} wstate_t;
    typedef enum logic [1:0] {R_DA, R_SA, R_LEN, R_PAY} rpos_t;

    logic [7:0]  mem [DEPTH];

    wstate_t     state;
    logic [AW:0] wr_ptr;
    logic [AW:0] cm_ptr;
    logic [7:0]  da_q;
    logic [7:0]  cnt;
    logic        wr_en;
    logic        commit;
    logic        hdr_bad;

    rpos_t       rpos;
    logic [AW:0] rd_ptr;
    logic [AW:0] cm_rd;
    logic [7:0]  rcnt;
    logic [7:0]  rd_byte;

    always_comb begin
        hdr_bad = (data_in > MAX_LEN_B) || (da_q >= NUM_PORTS_B);
        wr_en   = 1'b0;
        commit  = 1'b0;
        if (sw_enable_in) begin
            case (state)
                S_IDLE: wr_en = !read_out;
                S_SA:   wr_en = 1'b1;
                S_LEN: begin
                    wr_en  = 1'b1;
                    commit = !hdr_bad && (data_in == 8'd0);
                end
                S_PAY: begin
                    wr_en  = 1'b1;
                    commit = (cnt == 8'd1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= data_in;
    end

    // Write-side framing FSM
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state  <= S_IDLE;
            wr_ptr <= '0;
            cm_ptr <= '0;
            da_q   <= '0;
            cnt    <= '0;
        end else begin
            if (commit) cm_ptr <= wr_ptr + 1'b1;
            case (state)
                S_IDLE: begin
                    if (sw_enable_in) begin
                        if (read_out) begin
                            state <= S_DROP;
                        end else begin
                            da_q   <= data_in;
                            wr_ptr <= wr_ptr + 1'b1;
                            state  <= S_SA;
                        end
                    end
                end
                S_SA: begin
                    if (!sw_enable_in) begin
                        wr_ptr <= cm_ptr;
                        state  <= S_IDLE;
                    end else begin
                        wr_ptr <= wr_ptr + 1'b1;
                        state  <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (!sw_enable_in) begin
                        wr_ptr <= cm_ptr;
                        state  <= S_IDLE;
                    end else if (hdr_bad) begin
                        wr_ptr <= cm_ptr;
                        state  <= S_DROP;
                    end else begin
                        wr_ptr <= wr_ptr + 1'b1;
                        cnt    <= data_in;
                        state  <= commit ? S_SKIP : S_PAY;
                    end
                end
                S_PAY: begin
                    if (!sw_enable_in) begin
                        wr_ptr <= cm_ptr;
                        state  <= S_IDLE;
                    end else begin
                        wr_ptr <= wr_ptr + 1'b1;
                        cnt    <= cnt - 8'd1;
                        if (commit) state <= S_SKIP;
                    end
                end
                S_DROP: begin
                    wr_ptr <= cm_ptr;
                    if (!sw_enable_in) state <= S_IDLE;
                end
                default: begin
                    if (!sw_enable_in) state <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_byte = mem[rd_ptr[AW-1:0]];

    // Read side works from a one-cycle-delayed copy of the commit pointer,
    // which sets the DA presentation two clocks after the committing edge.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cm_rd     <= '0;
            rd_ptr    <= '0;
            rpos      <= R_DA;
            rcnt      <= '0;
            read_out  <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_dest  <= '0;
        end else begin
            cm_rd    <= cm_ptr;
            read_out <= (DEPTH_P - (cm_ptr - rd_ptr)) < ROOM;
            if (!out_valid || out_ready) begin
                if (rd_ptr != cm_rd) begin
                    out_data  <= rd_byte;
                    out_valid <= 1'b1;
                    out_sop   <= (rpos == R_DA);
                    out_eop   <= 1'b0;
                    rd_ptr    <= rd_ptr + 1'b1;
                    case (rpos)
                        R_DA: begin
                            out_dest <= rd_byte[1:0];
                            rpos     <= R_SA;
                        end
                        R_SA: rpos <= R_LEN;
                        R_LEN: begin
                            rcnt <= rd_byte;
                            if (rd_byte == 8'd0) begin
                                out_eop <= 1'b1;
                                rpos    <= R_DA;
                            end else begin
                                rpos <= R_PAY;
                            end
                        end
                        default: begin
                            rcnt <= rcnt - 8'd1;
                            if (rcnt == 8'd1) begin
                                out_eop <= 1'b1;
                                rpos    <= R_DA;
                            end
                        end
                    endcase
                end else begin
                    out_valid <= 1'b0;
                    out_sop   <= 1'b0;
                    out_eop   <= 1'b0;
                end
            end
        end
    end

`ifdef SW_IN_PKT_CNT_EN
    logic drop_ev;

    // Every started packet that does not commit is counted exactly once:
    // on DROP entry or on an abort.
    always_comb begin
        drop_ev = 1'b0;
        case (state)
            S_IDLE:       drop_ev = sw_enable_in && read_out;
            S_SA, S_PAY:  drop_ev = !sw_enable_in;
            S_LEN:        drop_ev = !sw_enable_in || hdr_bad;
            default:      drop_ev = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pkt_ok_cnt   <= '0;
            pkt_drop_cnt <= '0;
        end else begin
            if (commit && (pkt_ok_cnt != '1))    pkt_ok_cnt   <= pkt_ok_cnt + 1'b1;
            if (drop_ev && (pkt_drop_cnt != '1)) pkt_drop_cnt <= pkt_drop_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_switch_in_port.sv
module tb_switch_in_port;

    localparam int DEPTH     = 128;
    localparam int MAX_LEN   = 32;
    localparam int NUM_PORTS = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] data_in = '0;
    logic       sw_enable_in = 1'b0;
    logic       read_out;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_sop;
    logic       out_eop;
    logic [1:0] out_dest;
`ifdef SW_IN_PKT_CNT_EN
    logic [15:0] pkt_ok_cnt;
    logic [15:0] pkt_drop_cnt;
`endif

    always #5 clk = ~clk;

    switch_in_port #(
        .DEPTH     (DEPTH),
        .MAX_LEN   (MAX_LEN),
        .NUM_PORTS (NUM_PORTS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .sw_enable_in (sw_enable_in),
        .read_out     (read_out),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sop      (out_sop),
        .out_eop      (out_eop),
        .out_dest     (out_dest)
`ifdef SW_IN_PKT_CNT_EN
        ,
        .pkt_ok_cnt   (pkt_ok_cnt),
        .pkt_drop_cnt (pkt_drop_cnt)
`endif
    );

    typedef struct {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic [1:0] dest;
    } exp_t;

    // Reference model: packet-level view of what the core must receive.
    exp_t       exp_q[$];
    logic [7:0] pay_q[$];
    int         committed_b = 0;
    int         accepted_b  = 0;
    int         ok_m        = 0;
    int         started_m   = 0;
    int         rdy_mode    = 0;
    int         total       = 0;
    int         bad         = 0;
    exp_t       mon_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        committed_b = 0;
        accepted_b  = 0;
        ok_m        = 0;
        started_m   = 0;
    endtask

    // Sends the first n bytes of packet (da, sa, len, payload); if the whole
    // packet was sent, 'extra' overrun bytes follow with sw_enable_in held high.
    task automatic send_pkt(input logic [7:0] da, input logic [7:0] sa,
                            input logic [7:0] len, input int n, input int extra);
        logic [7:0] b[$];
        logic       busy;
        logic       good;
        int         occ;
        exp_t       e;
        b.push_back(da);
        b.push_back(sa);
        b.push_back(len);
        for (int i = 0; i < int'(len); i++)
            b.push_back((pay_q.size() != 0) ? pay_q.pop_front() : 8'($urandom));
        occ  = committed_b - accepted_b;
        busy = (DEPTH - occ) < (MAX_LEN + 3);
        good = !busy && (int'(da) < NUM_PORTS) && (int'(len) <= MAX_LEN) && (n == 3 + int'(len));
        started_m++;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            data_in      = b[i];
            sw_enable_in = 1'b1;
            if (i == 0) check("busy_at_start", read_out, busy);
        end
        @(posedge clk);
        if (good) begin
            for (int i = 0; i < b.size(); i++) begin
                e.data = b[i];
                e.sop  = (i == 0);
                e.eop  = (i == b.size() - 1);
                e.dest = da[1:0];
                exp_q.push_back(e);
            end
            committed_b += 3 + int'(len);
            ok_m++;
        end
        #1;
        if (n == 3 + int'(len)) begin
            for (int j = 0; j < extra; j++) begin
                data_in = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        sw_enable_in = 1'b0;
    endtask

    task automatic wait_room();
        int k = 0;
        while ((committed_b - accepted_b) > (DEPTH - MAX_LEN - 3 - 4) && k < 500) begin
            @(posedge clk);
            k++;
        end
        if (k >= 500) check("room_timeout", committed_b - accepted_b, 0);
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(posedge clk);
            k++;
        end
        if (k >= 3000) check("drain_timeout", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_valid", out_valid, 1'b0);
    endtask

    // out_ready driver
    initial begin
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Scoreboard: every accepted byte is matched against the model queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_byte", out_valid, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("data", out_data, mon_e.data);
                    check("sop", out_sop, mon_e.sop);
                    check("eop", out_eop, mon_e.eop);
                    check("dest", out_dest, mon_e.dest);
                    accepted_b++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_sop", out_sop, 1'b0);
        check("rst_eop", out_eop, 1'b0);
        check("rst_data", out_data, 8'h00);
        check("rst_dest", out_dest, 2'd0);
        check("rst_busy", read_out, 1'b0);
`ifdef SW_IN_PKT_CNT_EN
        check("rst_ok_cnt", pkt_ok_cnt, 16'd0);
        check("rst_drop_cnt", pkt_drop_cnt, 16'd0);
`endif
        rst_n = 1'b0;
        @(posedge clk); #1;

        // Basic packet, latency and back-to-back streaming
        rdy_mode = 1;
        pay_q.push_back(8'hAA);
        pay_q.push_back(8'hBB);
        send_pkt(8'd1, 8'd7, 8'd2, 5, 0);
        @(negedge clk);
        check("lat_early", out_valid, 1'b0);
        @(negedge clk);
        check("lat_one", out_valid, 1'b0);
        @(negedge clk);
        check("lat_rise", out_valid, 1'b1);
        check("lat_sop", out_sop, 1'b1);
        check("lat_da", out_data, 8'h01);
        check("lat_dest", out_dest, 2'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stream_valid", out_valid, 1'b1);
        end
        @(negedge clk);
        check("stream_end", out_valid, 1'b0);
        drain();

        // Zero-length packet
        send_pkt(8'd2, 8'h33, 8'd0, 3, 0);
        drain();

        // Unroutable DA, oversize LEN, then a good packet
        send_pkt(8'd5, 8'd1, 8'd2, 5, 0);
        send_pkt(8'd1, 8'd2, 8'd33, 6, 0);
        send_pkt(8'd3, 8'd4, 8'd4, 7, 0);
        drain();
`ifdef SW_IN_PKT_CNT_EN
        check("drop_cnt_hdr", pkt_drop_cnt, started_m - ok_m);
`endif

        // Abort after one of four payload bytes, then a good packet
        send_pkt(8'd0, 8'd9, 8'd4, 4, 0);
        send_pkt(8'd2, 8'd8, 8'd1, 4, 2);
        drain();
        check("abort_busy", read_out, 1'b0);

        // Back-pressure fills the buffer until busy
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        for (int k = 0; k < 3; k++)
            send_pkt(8'(k), 8'(16 + k), 8'd32, 35, 0);
        repeat (2) @(posedge clk);
        #1;
        check("full_busy", read_out, (DEPTH - (committed_b - accepted_b)) < (MAX_LEN + 3));
        send_pkt(8'd3, 8'h44, 8'd1, 4, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1'b1);
            check("hold_data", out_data, exp_q[0].data);
            check("hold_sop", out_sop, exp_q[0].sop);
        end
        rdy_mode = 1;
        drain();
        check("busy_clear", read_out, (DEPTH - (committed_b - accepted_b)) < (MAX_LEN + 3));

        // Reset mid-payload while a byte is stalled on the output
        rdy_mode = 0;
        send_pkt(8'd2, 8'd5, 8'd3, 6, 0);
        repeat (4) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            sw_enable_in = 1'b1;
            data_in      = (i == 2) ? 8'd8 : 8'(i + 1);
        end
        #2;
        rst_n = 1'b1;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_sop", out_sop, 1'b0);
        check("arst_eop", out_eop, 1'b0);
        check("arst_data", out_data, 8'h00);
        check("arst_dest", out_dest, 2'd0);
        check("arst_busy", read_out, 1'b0);
`ifdef SW_IN_PKT_CNT_EN
        check("arst_ok_cnt", pkt_ok_cnt, 16'd0);
`endif
        model_clear();
        sw_enable_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b0;
        rdy_mode = 1;
        @(posedge clk); #1;
        send_pkt(8'd3, 8'd6, 8'd2, 5, 0);
        drain();

        // Randomized mix with random back-pressure
        rdy_mode = 2;
        for (int p = 0; p < 40; p++) begin
            int         kind;
            int         n;
            int         extra;
            logic [7:0] da;
            logic [7:0] len;
            kind  = int'($urandom_range(0, 4));
            extra = 0;
            case (kind)
                0, 1: begin
                    da    = 8'($urandom_range(0, NUM_PORTS - 1));
                    len   = (p % 8 == 0) ? 8'(MAX_LEN) : 8'($urandom_range(0, MAX_LEN));
                    n     = 3 + int'(len);
                    extra = int'($urandom_range(0, 2));
                end
                2: begin
                    da  = 8'($urandom_range(NUM_PORTS, 255));
                    len = 8'($urandom_range(0, MAX_LEN));
                    n   = 3 + int'(len);
                end
                3: begin
                    da  = 8'($urandom_range(0, NUM_PORTS - 1));
                    len = 8'($urandom_range(MAX_LEN + 1, 255));
                    n   = 3 + int'($urandom_range(0, 5));
                end
                default: begin
                    da  = 8'($urandom_range(0, NUM_PORTS - 1));
                    len = 8'($urandom_range(1, MAX_LEN));
                    n   = int'($urandom_range(1, 2 + int'(len)));
                end
            endcase
            wait_room();
            send_pkt(da, 8'($urandom), len, n, extra);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        rdy_mode = 1;
        drain();
`ifdef SW_IN_PKT_CNT_EN
        check("final_ok_cnt", pkt_ok_cnt, ok_m);
        check("final_drop_cnt", pkt_drop_cnt, started_m - ok_m);
`endif
        check("final_busy", read_out, (DEPTH - (committed_b - accepted_b)) < (MAX_LEN + 3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
